regfile_mp_scoreboard: RTL and testbench

//  Parametrised multi-read-port integer register file for the RV32IM pipeline, replacing the fixed 2R1W file.

---
 rtl/regfile_mp_scoreboard_pkg.sv | 25 ++
 rtl/regfile_mp_scoreboard_if.sv | 44 ++++
 rtl/regfile_mp_scoreboard_sb.sv | 81 ++++++++
 rtl/regfile_mp_scoreboard.sv | 80 ++++++++
 tb/tb_regfile_mp_scoreboard.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and width helpers for the multi-read-port register file
// and its pending-write scoreboard.
//   DATA_W_DEF   : default register width
//   NUM_REGS_DEF : default register count
//   X0_IDX       : index of the hardwired-zero register
//   addr_w()     : address width for a given register count
//   cnt_w()      : counter width able to hold 0..max_inflight
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int X0_IDX       = 0;

    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    function automatic int cnt_w(input int max_inflight);
        return (max_inflight > 0) ? $clog2(max_inflight + 1) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_scoreboard_if
// Bundle between the ID stage (master) and the register file (slave).
//   RD_ADRS      : packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   RD_DATA      : packed read data, port p at [p*DATA_W +: DATA_W]
//   RD_BUSY      : per read port, source register has a pending write
//   WRITE_ENABLE / WB_ADDRESS / WRITE_DATA : writeback from WB
//   ISSUE_VALID / ISSUE_RD : destination of the instruction leaving ID
//   ISSUE_STALL  : destination counter is full, hold ISSUE_VALID off
//   FLUSH        : clear all pending-write counters
// ----------------------------------------------------------------------------
interface regfile_mp_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_READ = 2
);
    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [NUM_READ*ADDR_W-1:0] RD_ADRS;
    logic [NUM_READ*DATA_W-1:0] RD_DATA;
    logic [NUM_READ-1:0]        RD_BUSY;
    logic                       WRITE_ENABLE;
    logic [ADDR_W-1:0]          WB_ADDRESS;
    logic [DATA_W-1:0]          WRITE_DATA;
    logic                       ISSUE_VALID;
    logic [ADDR_W-1:0]          ISSUE_RD;
    logic                       ISSUE_STALL;
    logic                       FLUSH;

    modport master (
        output RD_ADRS, WRITE_ENABLE, WB_ADDRESS, WRITE_DATA,
               ISSUE_VALID, ISSUE_RD, FLUSH,
        input  RD_DATA, RD_BUSY, ISSUE_STALL
    );

    modport slave (
        input  RD_ADRS, WRITE_ENABLE, WB_ADDRESS, WRITE_DATA,
               ISSUE_VALID, ISSUE_RD, FLUSH,
        output RD_DATA, RD_BUSY, ISSUE_STALL
    );

endinterface

// File: rtl/regfile_mp_scoreboard_sb.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register pending-write counters used for hazard stalls.
//   CLK, RESET   : clock, synchronous active-high reset
//   issue_valid, issue_rd : issuing instruction and its destination
//   wb_en, wb_addr        : writeback strobe and register
//   flush                 : clear every counter
//   rd_adrs  -> rd_busy   : per read port, source has writes outstanding
//   issue_stall           : destination counter already at MAX_INFLIGHT
// Optional feature macro: REGFILE_BYPASS_EN (a writeback retiring the last
// pending write of a read source clears RD_BUSY in the same cycle).
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS     = NUM_REGS_DEF,
    parameter  int NUM_READ     = 2,
    parameter  int MAX_INFLIGHT = 3,
    parameter  int ZERO_REG     = 1,
    localparam int ADDR_W       = addr_w(NUM_REGS),
    localparam int CNT_W        = cnt_w(MAX_INFLIGHT)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_rd,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic                       flush,
    input  logic [NUM_READ*ADDR_W-1:0] rd_adrs,
    output logic [NUM_READ-1:0]        rd_busy,
    output logic                       issue_stall
);

    logic [CNT_W-1:0]  cnt [NUM_REGS];
    logic              issue_ok;
    logic [ADDR_W-1:0] rd_addr [NUM_READ];

    // A writeback to the same register frees a slot this cycle, so a full
    // counter may still accept the issue (net count unchanged).
    assign issue_stall = (cnt[issue_rd] == CNT_W'(MAX_INFLIGHT))
                         && !(wb_en && (wb_addr == issue_rd));
    assign issue_ok    = issue_valid && !issue_stall;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        localparam bit TRACKED = !((ZERO_REG != 0) && (r == X0_IDX));
        logic inc;
        logic dec;

        assign inc = TRACKED && issue_ok && (issue_rd == ADDR_W'(r));
        assign dec = TRACKED && wb_en    && (wb_addr  == ADDR_W'(r));

        // NOTE: state is updated with non-blocking assignments so every
        // counter samples the same pre-edge values regardless of order.
        always_ff @(posedge CLK) begin
            if (RESET || flush) begin
                cnt[r] <= '0;
            end else if (inc && !dec) begin
                cnt[r] <= cnt[r] + 1'b1;
            end else if (dec && !inc && (cnt[r] != '0)) begin
                cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            rd_addr[p] = rd_adrs[p*ADDR_W +: ADDR_W];
            rd_busy[p] = (cnt[rd_addr[p]] != '0);
`ifdef REGFILE_BYPASS_EN
            // The last outstanding write lands this cycle and is bypassed.
            if (wb_en && (wb_addr == rd_addr[p]) && (cnt[rd_addr[p]] == CNT_W'(1)))
                rd_busy[p] = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_mp_scoreboard
// Multi-read-port integer register file for the RV32IM ID stage with a
// hardwired-zero x0 and a per-register pending-write scoreboard.
//   CLK   : clock, all state updates on the rising edge
//   RESET : synchronous, active-high; clears registers and counters
//   bus   : regfile_mp_scoreboard_if slave (reads, writeback, issue, flush)
// Optional feature macro: REGFILE_BYPASS_EN -- a writeback to a read source
// is forwarded to RD_DATA in the same cycle (never for x0). Without it reads
// return the stored value until the clock edge.
// ----------------------------------------------------------------------------
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int NUM_REGS     = NUM_REGS_DEF,
    parameter int NUM_READ     = 2,
    parameter int MAX_INFLIGHT = 3,
    parameter int ZERO_REG     = 1
) (
    input logic                   CLK,
    input logic                   RESET,
    regfile_mp_scoreboard_if.slave bus
);

    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [DATA_W-1:0] regs    [NUM_REGS];
    logic [ADDR_W-1:0] rd_addr [NUM_READ];
    logic [DATA_W-1:0] rd_word [NUM_READ];
    logic              wb_ok;

    assign wb_ok = bus.WRITE_ENABLE
                   && !((ZERO_REG != 0) && (bus.WB_ADDRESS == ADDR_W'(X0_IDX)));

    // NOTE: the storage array is reset because software-visible registers
    // must read zero after reset; this costs a reset path on every flop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            regs[bus.WB_ADDRESS] <= bus.WRITE_DATA;
        end
    end

    always_comb begin
        bus.RD_DATA = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            rd_addr[p] = bus.RD_ADRS[p*ADDR_W +: ADDR_W];
            rd_word[p] = regs[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wb_ok && (bus.WB_ADDRESS == rd_addr[p]))
                rd_word[p] = bus.WRITE_DATA;
`endif
            // x0 is forced at the mux so it reads zero regardless of storage.
            if ((ZERO_REG != 0) && (rd_addr[p] == ADDR_W'(X0_IDX)))
                rd_word[p] = '0;
            bus.RD_DATA[p*DATA_W +: DATA_W] = rd_word[p];
        end
    end

    regfile_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .NUM_READ     (NUM_READ),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .ZERO_REG     (ZERO_REG)
    ) u_scoreboard (
        .CLK         (CLK),
        .RESET       (RESET),
        .issue_valid (bus.ISSUE_VALID),
        .issue_rd    (bus.ISSUE_RD),
        .wb_en       (bus.WRITE_ENABLE),
        .wb_addr     (bus.WB_ADDRESS),
        .flush       (bus.FLUSH),
        .rd_adrs     (bus.RD_ADRS),
        .rd_busy     (bus.RD_BUSY),
        .issue_stall (bus.ISSUE_STALL)
    );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp_scoreboard
// Directed stimulus for regfile_mp_scoreboard (4 read ports). Each stimulus
// cycle queues its expected outputs tagged with the cycle number; a monitor
// on the falling edge pops and compares them. Honors REGFILE_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_regfile_mp_scoreboard;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NP = 4;
    localparam int AW = 5;

    localparam int K_DATA  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_STALL = 2;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] exp;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   next_id = 0;
    exp_t sbq[$];

    regfile_mp_scoreboard_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_READ(NP)) bus ();

    regfile_mp_scoreboard #(
        .DATA_W(DW), .NUM_REGS(NR), .NUM_READ(NP), .MAX_INFLIGHT(3), .ZERO_REG(1)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_DATA:  return "rd_data";
            K_BUSY:  return "rd_busy";
            default: return "issue_stall";
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [31:0] act;
        case (e.kind)
            K_DATA:  act = bus.RD_DATA[e.port*DW +: DW];
            K_BUSY:  act = {31'd0, bus.RD_BUSY[e.port]};
            default: act = {31'd0, bus.ISSUE_STALL};
        endcase
        total++;
        if (act !== e.exp) begin
            bad++;
            $display("FAIL %s p%0d chk#%0d cyc%0d: got %h want %h",
                     kname(e.kind), e.port, e.id, e.cyc, act, e.exp);
        end
    endtask

    // Monitor: compare everything queued for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            if (e.cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missed chk#%0d cyc%0d: got none want %h", e.id, e.cyc, e.exp);
            end else begin
                check(e);
            end
        end
    end

    task automatic want(input int kind, input int port, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.port = port; e.exp = v; e.id = next_id;
        next_id++;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.RD_ADRS[p*AW +: AW] = AW'(a);
    endtask

    task automatic wb(input logic en, input int a, input logic [31:0] d);
        bus.WRITE_ENABLE = en;
        bus.WB_ADDRESS   = AW'(a);
        bus.WRITE_DATA   = d;
    endtask

    task automatic issue(input logic v, input int a);
        bus.ISSUE_VALID = v;
        bus.ISSUE_RD    = AW'(a);
    endtask

    logic bypass;

    initial begin
`ifdef REGFILE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        rst = 1'b1;
        bus.RD_ADRS = '0;
        wb(1'b0, 0, 32'h0);
        issue(1'b0, 0);
        bus.FLUSH = 1'b0;

        // 1. Reset, all ports read x5.
        step();
        rst = 1'b0;
        for (int p = 0; p < NP; p++) set_rd(p, 5);
        for (int p = 0; p < NP; p++) begin
            want(K_DATA, p, 32'h0);
            want(K_BUSY, p, 32'h0);
        end
        want(K_STALL, 0, 32'h0);

        // 2. Write x7, read it back; write x0 is dropped.
        wb(1'b1, 7, 32'hDEADBEEF);
        step();
        wb(1'b1, 0, 32'h00001234);
        set_rd(0, 7);
        set_rd(1, 0);
        want(K_DATA, 0, 32'hDEADBEEF);
        want(K_DATA, 1, 32'h0);
        step();
        wb(1'b0, 0, 32'h0);
        want(K_DATA, 1, 32'h0);
        want(K_DATA, 0, 32'hDEADBEEF);

        // 3. Same-cycle write/read of x9.
        step();
        wb(1'b1, 9, 32'hA5A5A5A5);
        set_rd(2, 9);
        want(K_DATA, 2, bypass ? 32'hA5A5A5A5 : 32'h0);
        step();
        wb(1'b0, 0, 32'h0);
        want(K_DATA, 2, 32'hA5A5A5A5);

        // 4. Fill x3 to MAX_INFLIGHT, extra issues ignored, then drain.
        step();
        set_rd(3, 3);
        issue(1'b1, 3);
        want(K_BUSY, 3, 32'h0);
        want(K_STALL, 0, 32'h0);
        step();                                  // cnt 1
        want(K_BUSY, 3, 32'h1);
        want(K_STALL, 0, 32'h0);
        step();                                  // cnt 2
        want(K_STALL, 0, 32'h0);
        step();                                  // cnt 3, 4th issue held off
        want(K_BUSY, 3, 32'h1);
        want(K_STALL, 0, 32'h1);
        step();                                  // still 3
        want(K_STALL, 0, 32'h1);
        step();
        issue(1'b0, 3);
        wb(1'b1, 3, 32'h00000033);
        want(K_BUSY, 3, 32'h1);
        want(K_STALL, 0, 32'h0);                 // writeback to ISSUE_RD frees a slot
        step();                                  // cnt 2
        want(K_BUSY, 3, 32'h1);
        step();                                  // cnt 1
        want(K_BUSY, 3, bypass ? 32'h0 : 32'h1);
        step();                                  // cnt 0
        wb(1'b0, 0, 32'h0);
        want(K_BUSY, 3, 32'h0);
        want(K_DATA, 3, 32'h00000033);
        step();
        wb(1'b1, 3, 32'h00000044);               // writeback with cnt 0 saturates
        want(K_BUSY, 3, 32'h0);
        step();
        wb(1'b0, 0, 32'h0);
        want(K_BUSY, 3, 32'h0);
        want(K_STALL, 0, 32'h0);

        // 5. Issue + writeback same register same cycle, then flush.
        step();
        set_rd(0, 4);
        issue(1'b1, 4);
        step();                                  // cnt4 = 1
        wb(1'b1, 4, 32'h00004444);
        want(K_BUSY, 0, bypass ? 32'h0 : 32'h1);
        step();                                  // cnt4 stays 1
        issue(1'b0, 0);
        wb(1'b0, 0, 32'h0);
        want(K_BUSY, 0, 32'h1);
        want(K_DATA, 0, 32'h00004444);
        step();
        bus.FLUSH = 1'b1;
        issue(1'b1, 6);
        wb(1'b1, 10, 32'h0000F00D);
        set_rd(1, 6);
        set_rd(2, 10);
        want(K_BUSY, 0, 32'h1);
        want(K_BUSY, 1, 32'h0);
        step();
        bus.FLUSH = 1'b0;
        issue(1'b0, 0);
        wb(1'b0, 0, 32'h0);
        want(K_BUSY, 0, 32'h0);
        want(K_BUSY, 1, 32'h0);
        want(K_DATA, 2, 32'h0000F00D);

        // 6. Reset while cnt3 = 2 and a writeback to x3 is pending.
        step();
        set_rd(0, 7);
        set_rd(3, 3);
        issue(1'b1, 3);
        step();                                  // cnt3 = 1
        step();                                  // cnt3 = 2
        issue(1'b0, 3);
        rst = 1'b1;
        wb(1'b1, 3, 32'h00000BAD);
        want(K_BUSY, 3, 32'h1);
        step();
        rst = 1'b0;
        wb(1'b0, 0, 32'h0);
        want(K_DATA, 3, 32'h0);
        want(K_DATA, 0, 32'h0);
        want(K_BUSY, 3, 32'h0);
        want(K_STALL, 0, 32'h0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sbq.size() > 0; i++) step();
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL timeout chk#%0d: got none want %h", e.id, e.exp);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
